// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches words over a ready handshake,
// latches them in the instruction register and picks the next PC on downstream ack.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count,
  output logic        misalign_err
);

  // Handshakes: imem_req/imem_ready complete a read on an edge where both are 1;
  // instr_valid/instr_ack hand the held instruction downstream on an edge where both are 1.

  // Opcode encodings (mips.h). JR is an R-type word, so control flags it as jump with opcode 0.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        misalign_q, misalign_d;

  logic [31:0] next_pc;
  logic        is_jr;
  logic        taken;
  logic [31:0] br_offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      count_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    is_jr     = jump && (instr_q[31:26] == OP_RTYPE);
    taken     = ((instr_q[31:26] == OP_BEQ) && zero) ||
                ((instr_q[31:26] == OP_BNE) && !zero);
    br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    if (is_jr) begin
      next_pc = {jr_addr[31:2], 2'b00};
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (branch && taken) begin
      next_pc = pc_plus4 + br_offset;
    end else begin
      next_pc = pc_plus4;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    count_d    = count_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        if (instr_ack) begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          if (is_jr && (jr_addr[1:0] != 2'b00)) misalign_d = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoded from the state register so reset drops them without a clock.
  assign imem_req     = (state_q == FETCH);
  assign instr_valid  = (state_q == VALID);
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign instr        = instr_q;
  assign opcode       = instr_q[31:26];
  assign instr_count  = count_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios then random instruction
// streams checked against an arithmetic PC/count model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [5:0]  OP_R   = 6'h00;
  localparam logic [5:0]  OP_J   = 6'h02;
  localparam logic [5:0]  OP_JAL = 6'h03;
  localparam logic [5:0]  OP_BEQ = 6'h04;
  localparam logic [5:0]  OP_BNE = 6'h05;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ack;
  logic        jump;
  logic        branch;
  logic        zero;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr_count;
  logic        misalign_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_count;
  logic        m_mis;
  logic [31:0] exp_q[$];

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .instr_ack(instr_ack), .jump(jump), .branch(branch), .zero(zero),
    .jr_addr(jr_addr), .pc(pc), .pc_plus4(pc_plus4),
    .instr_count(instr_count), .misalign_err(misalign_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Next PC straight from the ISA rules, using plain integer arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic j, input logic b, input logic z,
                                             input logic [31:0] ra);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    if (j && w[31:26] == OP_R) return ra - (ra % 4);
    if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
    if (b && ((w[31:26] == OP_BEQ && z) || (w[31:26] == OP_BNE && !z))) begin
      off = int'($signed(w[15:0])) * 4;
      return seq + 32'(off);
    end
    return seq;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   {31'b0, imem_req},     32'd0);
    chk({tag, "_valid"}, {31'b0, instr_valid},  32'd0);
    chk({tag, "_pc"},    pc,                    RST_PC);
    chk({tag, "_instr"}, instr,                 32'd0);
    chk({tag, "_count"}, instr_count,           32'd0);
    chk({tag, "_mis"},   {31'b0, misalign_err}, 32'd0);
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = 32'd0; m_count = 32'd0; m_mis = 1'b0;
  endtask

  // Driver: called at a negedge while in FETCH; leaves the DUT in VALID at a negedge.
  task automatic fetch(input logic [31:0] word, input int waits);
    chk("fetch_req",  {31'b0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, m_pc);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      instr_ack  = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
      chk("wait_req",   {31'b0, imem_req},    32'd1);
      chk("wait_addr",  imem_addr,            m_pc);
      chk("wait_valid", {31'b0, instr_valid}, 32'd0);
    end
    instr_ack  = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = word;
    exp_q.push_back(word);
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    m_instr = exp_q.pop_front();
    chk("valid_rise", {31'b0, instr_valid}, 32'd1);
    chk("valid_req",  {31'b0, imem_req},    32'd0);
    chk("instr",      instr,                m_instr);
    chk("opcode",     {26'b0, opcode},      {26'b0, m_instr[31:26]});
    chk("pc_plus4",   pc_plus4,             m_pc + 32'd4);
  endtask

  // Driver: holds VALID for 'delay' cycles, then acks with the given control inputs.
  task automatic ack(input logic j, input logic b, input logic z, input logic [31:0] ra,
                     input int delay);
    logic [31:0] exp_pc;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("hold_pc",    pc,                   m_pc);
      chk("hold_instr", instr,                m_instr);
    end
    jump = j; branch = b; zero = z; jr_addr = ra; instr_ack = 1'b1;
    exp_pc = model_next(m_pc, m_instr, j, b, z, ra);
    if (j && m_instr[31:26] == OP_R && (ra % 4) != 0) m_mis = 1'b1;
    @(negedge clk);
    instr_ack = 1'b0;
    jump = 1'($urandom); branch = 1'($urandom); zero = 1'($urandom); jr_addr = $urandom;
    m_pc    = exp_pc;
    m_count = m_count + 32'd1;
    chk("ack_pc",    pc,                    m_pc);
    chk("ack_count", instr_count,           m_count);
    chk("ack_mis",   {31'b0, misalign_err}, {31'b0, m_mis});
    chk("ack_valid", {31'b0, instr_valid},  32'd0);
  endtask

  task automatic step(input logic [31:0] word, input logic j, input logic b, input logic z,
                      input logic [31:0] ra);
    fetch(word, 0);
    ack(j, b, z, ra, 0);
  endtask

  initial begin
    logic [31:0] w;
    int          kind;
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0; instr_ack = 1'b0;
    jump = 1'b0; branch = 1'b0; zero = 1'b0; jr_addr = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");

    // Reset release and first fetch of ADD
    rst_n = 1'b1;
    @(negedge clk);
    fetch(32'h0022_1820, 0);
    ack(1'b0, 1'b0, 1'b0, 32'd0, 0);
    chk("first_pc", pc, 32'h104);

    // Wait states with a stray ack while fetching
    fetch(32'h0043_2020, 3);
    ack(1'b0, 1'b0, 1'b0, 32'd0, 2);

    // Branches around 0x200
    step({OP_J, 26'h80}, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("j_to_200", pc, 32'h200);
    step({OP_BEQ, 5'd1, 5'd2, 16'hFFFE}, 1'b0, 1'b1, 1'b1, 32'd0);
    chk("beq_taken", pc, 32'h1FC);
    step({OP_J, 26'h80}, 1'b1, 1'b0, 1'b0, 32'd0);
    step({OP_BEQ, 5'd1, 5'd2, 16'hFFFE}, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("beq_not_taken", pc, 32'h204);
    step({OP_JAL, 26'h80}, 1'b1, 1'b0, 1'b0, 32'd0);
    step({OP_BNE, 5'd1, 5'd2, 16'hFFFE}, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("bne_taken", pc, 32'h1FC);

    // Jumps
    step(32'h0200_0008, 1'b1, 1'b0, 1'b0, 32'h1000_0000);
    step({OP_J, 26'h40}, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("j_region", pc, 32'h1000_0100);
    chk("mis_before", {31'b0, misalign_err}, 32'd0);
    step(32'h0200_0008, 1'b1, 1'b0, 1'b0, 32'h0000_3002);
    chk("jr_misalign_pc", pc, 32'h3000);
    chk("jr_misalign_flag", {31'b0, misalign_err}, 32'd1);
    step({OP_J, 10'h0, 16'h0800}, 1'b1, 1'b1, 1'b1, 32'd0);
    chk("jump_over_branch", pc, 32'h0000_2000);

    // Wrap at the top of the address space
    step(32'h0200_0008, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    step(32'h0022_1820, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("wrap_pc", pc, 32'h0);

    // Reset while fetching, with a memory response during reset
    imem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_fetch");
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk_reset_vals("rst_fetch_held");
    imem_ready = 1'b0;
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    fetch(32'h0022_1820, 1);

    // Reset while holding a valid instruction
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_valid");
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    fetch(32'h0043_2020, 0);
    ack(1'b0, 1'b0, 1'b0, 32'd0, 0);
    chk("restart_pc", pc, 32'h104);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      w = $urandom;
      case (kind)
        0: begin w[31:26] = OP_R;   fetch(w, $urandom_range(0, 2)); ack(1'b0, 1'b0, 1'($urandom), $urandom, $urandom_range(0, 2)); end
        1: begin w[31:26] = OP_R;   fetch(w, $urandom_range(0, 2)); ack(1'b1, 1'b0, 1'($urandom), $urandom, $urandom_range(0, 2)); end
        2: begin w[31:26] = OP_J;   fetch(w, $urandom_range(0, 2)); ack(1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom_range(0, 2)); end
        3: begin w[31:26] = OP_JAL; fetch(w, $urandom_range(0, 2)); ack(1'b1, 1'b0, 1'($urandom), $urandom, $urandom_range(0, 2)); end
        4: begin w[31:26] = OP_BEQ; fetch(w, $urandom_range(0, 2)); ack(1'b0, 1'b1, 1'($urandom), $urandom, $urandom_range(0, 2)); end
        default: begin w[31:26] = OP_BNE; fetch(w, $urandom_range(0, 2)); ack(1'b0, 1'b1, 1'($urandom), $urandom, $urandom_range(0, 2)); end
      endcase
    end

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
